// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the flow-controlled stage registers in the datapath.
//   state_e    : occupancy state of a two-entry skid register
//   PIPE_WIDTH : default data word width (MIPS word)
package pipe_skid_reg_pkg;

  localparam int PIPE_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // no words held
    ST_BUSY  = 2'd1,  // main holds a word, skid empty
    ST_FULL  = 2'd2   // main and skid both hold words
  } state_e;

endpackage

// File: rtl/pipe_skid_reg_en_reg.sv
// en_reg: enabled register with synchronous active-high reset and synchronous clear.
//   clk : rising-edge clock
//   rst : synchronous reset, q <= 0
//   clr : synchronous clear, q <= 0 (same effect as rst, lower priority)
//   en  : load d into q
//   d   : next data
//   q   : registered data
module en_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready skid buffer between processor stages.
// Absorbs one cycle of downstream backpressure; in_ready is registered so there
// is no combinational path from out_ready to in_ready.
//   clk       : rising-edge clock
//   rst       : synchronous reset, active-high (overrides flush)
//   flush     : synchronous squash of all held words
//   in_valid  : upstream word present
//   in_ready  : block can accept a word this cycle (registered)
//   in_data   : upstream word
//   out_valid : out_data holds a valid word (registered)
//   out_ready : downstream accepts out_data this cycle
//   out_data  : oldest held word (registered)
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_e           state;
  logic             load, unload;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign load   = in_valid & in_ready;
  assign unload = out_valid & out_ready;

  // Main reloads on first fill, on pass-through (load & unload while BUSY),
  // and from skid when a FULL buffer drains. Skid only captures on a stall.
  assign main_en = ((state == ST_EMPTY) & load) |
                   ((state == ST_BUSY)  & load & unload) |
                   ((state == ST_FULL)  & unload);
  assign main_d  = (state == ST_FULL) ? skid_q : in_data;
  assign skid_en = (state == ST_BUSY) & load & ~unload;

  en_reg #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  en_reg #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

  // Occupancy FSM; out_valid/in_ready are registered alongside the state so
  // they always reflect the state being entered.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (load) begin
            state     <= ST_BUSY;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (load && !unload) begin
            state     <= ST_FULL;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
          end else if (!load && unload) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        ST_FULL: begin
          if (unload) begin
            state     <= ST_BUSY;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          // unused encoding: fall back to a clean empty buffer
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: a queue model (words held, capacity 2) checked on
// every falling edge, plus directed literal expectations per scenario.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model[$];   // words held by the buffer, oldest first
  logic [31:0] got[$];     // words the DUT delivered to downstream
  int          n_acc = 0;
  bit          armed = 0;
  bit          stall_prev = 0;
  logic [31:0] stall_data;
  bit          ld, ul;

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: inputs are stable around the falling edge, so the falling edge
  // both checks the post-edge state and predicts the next rising edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("mdl_out_valid", {31'b0, out_valid}, {31'b0, model.size() > 0});
      chk("mdl_in_ready",  {31'b0, in_ready},  {31'b0, model.size() < 2});
      if (model.size() > 0) chk("mdl_out_data", out_data, model[0]);
      if (stall_prev && out_valid) chk("stall_stable", out_data, stall_data);
    end
    if (rst || flush) begin
      model.delete();
      stall_prev = 0;
      if (rst) armed = 1;
    end else if (armed) begin
      ld = in_valid && (model.size() < 2);
      ul = (model.size() > 0) && out_ready;
      if (out_valid && out_ready) got.push_back(out_data);
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (ul) void'(model.pop_front());
      if (ld) begin
        model.push_back(in_data);
        n_acc++;
      end
    end
  end

  // Apply inputs, take one rising edge, return just after it.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic bit seen(input logic [31:0] w);
    foreach (got[i]) if (got[i] == w) return 1;
    return 0;
  endfunction

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;

    // 1: reset
    step(0, 32'h0, 0);
    step(0, 32'h0, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_data",  out_data, 32'h0);
    rst = 0;
    step(0, 32'h0, 0);
    chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_in_ready",  {31'b0, in_ready},  32'd1);

    // 2: streaming, 1-cycle latency, in_ready never drops
    got.delete();
    for (int i = 1; i <= 10; i++) begin
      step(1, i, 1);
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
      chk("stream_data",  out_data, i);
      chk("stream_ready", {31'b0, in_ready}, 32'd1);
    end
    step(0, 32'h0, 1);
    chk("stream_drained", {31'b0, out_valid}, 32'd0);
    chk("stream_count", got.size(), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++) chk("stream_order", got[i], i + 1);

    // 3: backpressure
    got.delete();
    step(1, 32'hAAAA0001, 0);
    chk("bp1_data",  out_data, 32'hAAAA0001);
    chk("bp1_ready", {31'b0, in_ready}, 32'd1);
    step(1, 32'hAAAA0002, 0);
    chk("bp2_ready", {31'b0, in_ready}, 32'd0);
    chk("bp2_data",  out_data, 32'hAAAA0001);
    step(1, 32'h0000DEAD, 0);
    chk("bp3_ready", {31'b0, in_ready}, 32'd0);
    chk("bp3_data",  out_data, 32'hAAAA0001);
    step(0, 32'h0, 1);
    chk("bp4_data",  out_data, 32'hAAAA0002);
    chk("bp4_ready", {31'b0, in_ready}, 32'd1);
    step(0, 32'h0, 1);
    chk("bp5_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_count", got.size(), 32'd2);
    if (got.size() == 2) begin
      chk("bp_w0", got[0], 32'hAAAA0001);
      chk("bp_w1", got[1], 32'hAAAA0002);
    end
    chk("bp_no_dead", {31'b0, seen(32'h0000DEAD)}, 32'd0);

    // 4: flush while FULL with a word offered
    got.delete();
    step(1, 32'h11110000, 0);
    step(1, 32'h22220000, 0);
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1;
    step(1, 32'h12345678, 1);
    flush = 0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_ready", {31'b0, in_ready},  32'd1);
    chk("fl_data",  out_data, 32'h0);
    step(0, 32'h0, 1);
    step(0, 32'h0, 1);
    chk("fl_still_empty", {31'b0, out_valid}, 32'd0);
    chk("fl_no_word", {31'b0, seen(32'h12345678)}, 32'd0);
    chk("fl_none_out", got.size(), 32'd0);

    // 5: rst and flush together mid-stream
    step(1, 32'h5, 1);
    step(1, 32'h6, 0);
    rst = 1; flush = 1;
    step(1, 32'h7, 1);
    rst = 0; flush = 0;
    chk("rf_valid", {31'b0, out_valid}, 32'd0);
    chk("rf_ready", {31'b0, in_ready},  32'd1);
    chk("rf_data",  out_data, 32'h0);
    got.delete();
    step(1, 32'hCAFEF00D, 0);
    chk("cafe_valid", {31'b0, out_valid}, 32'd1);
    chk("cafe_data",  out_data, 32'hCAFEF00D);
    step(0, 32'h0, 1);
    chk("cafe_out", got.size(), 32'd1);
    if (got.size() == 1) chk("cafe_word", got[0], 32'hCAFEF00D);

    // 6: random traffic; model checks every cycle, then totals must match
    got.delete();
    n_acc = 0;
    for (int c = 0; c < 1000; c++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
    for (int c = 0; c < 4; c++) step(0, 32'h0, 1);
    chk("rand_drained", {31'b0, out_valid}, 32'd0);
    chk("rand_totals", got.size(), n_acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
